// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU run one radix-2 step per cycle. MTHI/MTLO write in one cycle.
// Ports:
//   in_clk, in_rst              clock, async active-high reset
//   in_start, in_cmd            issue request and command (0 none .. 6 MTLO)
//   in_a, in_b                  rs / rt operands
//   in_flush                    abort the in-flight operation
//   in_rd_req                   decode holds MFHI/MFLO
//   out_busy, out_stall         in-flight flag, combinational stall request
//   out_hi_wena, out_lo_wena    one-cycle HI/LO write pulses
//   out_hi_data, out_lo_data    write data, valid while the matching wena is high
//   out_hi, out_lo              architectural HI/LO
module muldiv_hilo #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] DIVZ_LO = {DATA_W{1'b1}}
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    input  logic [2:0]        in_cmd,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_flush,
    input  logic              in_rd_req,
    output logic              out_busy,
    output logic              out_stall,
    output logic              out_hi_wena,
    output logic              out_lo_wena,
    output logic [DATA_W-1:0] out_hi_data,
    output logic [DATA_W-1:0] out_lo_data,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo
);

    localparam int            CW   = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    localparam logic [2:0] CMD_MULT  = 3'd1;
    localparam logic [2:0] CMD_MULTU = 3'd2;
    localparam logic [2:0] CMD_DIV   = 3'd3;
    localparam logic [2:0] CMD_DIVU  = 3'd4;
    localparam logic [2:0] CMD_MTHI  = 3'd5;
    localparam logic [2:0] CMD_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_MOVE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic              is_div, neg_q, neg_r, divz, mv_hi;
    // opnd: multiplicand for multiply, divisor for divide.
    // acc_lo: multiplier shifting out / quotient shifting in.
    logic [DATA_W-1:0] opnd, acc_hi, acc_lo, a_lat, hi_r, lo_r;

    logic              cmd_md, cmd_mv, cmd_div, cmd_sgn;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] mag_a, mag_b;

    assign cmd_md  = in_cmd inside {CMD_MULT, CMD_MULTU, CMD_DIV, CMD_DIVU};
    assign cmd_mv  = in_cmd inside {CMD_MTHI, CMD_MTLO};
    assign cmd_div = in_cmd inside {CMD_DIV, CMD_DIVU};
    assign cmd_sgn = in_cmd inside {CMD_MULT, CMD_DIV};
    assign a_neg   = cmd_sgn & in_a[DATA_W-1];
    assign b_neg   = cmd_sgn & in_b[DATA_W-1];
    assign mag_a   = a_neg ? -in_a : in_a;
    assign mag_b   = b_neg ? -in_b : in_b;

    logic [DATA_W:0]     mul_sum, div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   div_sub;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi, res_lo;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    // When div_ge holds the difference is below the divisor, so it fits DATA_W bits.
    assign div_sub   = div_shift[DATA_W-1:0] - opnd;
    assign prod      = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

    always_comb begin
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (is_div) begin
            if (divz) begin
                res_hi = a_lat;
                res_lo = DIVZ_LO;
            end else begin
                res_hi = neg_r ? -acc_hi : acc_hi;
                res_lo = neg_q ? -acc_lo : acc_lo;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        out_busy    = 1'b0;
        out_hi_wena = 1'b0;
        out_lo_wena = 1'b0;
        out_hi_data = '0;
        out_lo_data = '0;
        unique case (state)
            S_IDLE: begin
                if (in_start && !in_flush) begin
                    if (cmd_md)      state_nxt = S_CALC;
                    else if (cmd_mv) state_nxt = S_MOVE;
                end
            end
            S_CALC: begin
                out_busy = 1'b1;
                if (in_flush)         state_nxt = S_IDLE;
                else if (cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_busy    = 1'b1;
                state_nxt   = S_IDLE;
                out_hi_data = res_hi;
                out_lo_data = res_lo;
                out_hi_wena = !in_flush;
                out_lo_wena = !in_flush;
            end
            S_MOVE: begin
                out_busy  = 1'b1;
                state_nxt = S_IDLE;
                if (mv_hi) begin
                    out_hi_data = a_lat;
                    out_hi_wena = !in_flush;
                end else begin
                    out_lo_data = a_lat;
                    out_lo_wena = !in_flush;
                end
            end
        endcase
    end

    assign out_stall = (state != S_IDLE) &&
                       ((in_start && (cmd_md || cmd_mv)) || in_rd_req);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            divz   <= 1'b0;
            mv_hi  <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            a_lat  <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            if (state == S_IDLE && in_start && !in_flush && (cmd_md || cmd_mv)) begin
                cnt    <= '0;
                is_div <= cmd_div;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                divz   <= (in_b == '0);
                mv_hi  <= (in_cmd == CMD_MTHI);
                a_lat  <= in_a;
                acc_hi <= '0;
                opnd   <= cmd_div ? mag_b : mag_a;
                acc_lo <= cmd_div ? mag_a : mag_b;
            end else if (state == S_CALC) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    acc_hi <= div_ge ? div_sub : div_shift[DATA_W-1:0];
                    acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
                end else begin
                    acc_hi <= mul_sum[DATA_W:1];
                    acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                end
            end
            if (out_hi_wena) hi_r <= out_hi_data;
            if (out_lo_wena) lo_r <= out_lo_data;
        end
    end

    assign out_hi = hi_r;
    assign out_lo = lo_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed and randomized checks of muldiv_hilo against an
// arithmetic reference model of the HI/LO results and cycle timing.
module tb_muldiv_hilo;

    logic        in_clk = 1'b0;
    logic        in_rst, in_start, in_flush, in_rd_req;
    logic [2:0]  in_cmd;
    logic [31:0] in_a, in_b;
    logic        out_busy, out_stall, out_hi_wena, out_lo_wena;
    logic [31:0] out_hi_data, out_lo_data, out_hi, out_lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    muldiv_hilo dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_start    (in_start),
        .in_cmd      (in_cmd),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_flush    (in_flush),
        .in_rd_req   (in_rd_req),
        .out_busy    (out_busy),
        .out_stall   (out_stall),
        .out_hi_wena (out_hi_wena),
        .out_lo_wena (out_lo_wena),
        .out_hi_data (out_hi_data),
        .out_lo_data (out_lo_data),
        .out_hi      (out_hi),
        .out_lo      (out_lo)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} computed from the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (c)
            3'd1: p = 64'(sa * sb);
            3'd2: p = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else        p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
        logic [63:0] e;
        e = model(c, a, b);
        in_start = 1'b1;
        in_cmd   = c;
        in_a     = a;
        in_b     = b;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        in_cmd = 3'd0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge in_clk);
            chk({tag, " flags"}, 64'({out_busy, out_hi_wena, out_lo_wena}),
                64'({1'b1, k == 33, k == 33}));
            if (k == 33) chk({tag, " wdata"}, {out_hi_data, out_lo_data}, e);
        end
        @(negedge in_clk);
        chk({tag, " idle"}, 64'({out_busy, out_hi_wena, out_lo_wena}), 64'd0);
        chk({tag, " hilo"}, {out_hi, out_lo}, e);
        mhi = e[63:32];
        mlo = e[31:0];
    endtask

    task automatic mv(input logic to_hi, input logic [31:0] v, input string tag);
        in_start = 1'b1;
        in_cmd   = to_hi ? 3'd5 : 3'd6;
        in_a     = v;
        in_b     = $urandom;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        in_cmd = 3'd0;
        @(negedge in_clk);
        chk({tag, " flags"}, 64'({out_busy, out_hi_wena, out_lo_wena}),
            64'({1'b1, to_hi, !to_hi}));
        chk({tag, " wdata"}, 64'(to_hi ? out_hi_data : out_lo_data), 64'(v));
        if (to_hi) mhi = v;
        else       mlo = v;
        @(negedge in_clk);
        chk({tag, " idle"}, 64'(out_busy), 64'd0);
        chk({tag, " hilo"}, {out_hi, out_lo}, {mhi, mlo});
    endtask

    initial begin
        logic [63:0] e;
        logic [31:0] ra, rb, hv;
        logic [2:0]  rc;

        in_rst    = 1'b1;
        in_start  = 1'b0;
        in_flush  = 1'b0;
        in_rd_req = 1'b0;
        in_cmd    = 3'd0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(negedge in_clk);
        chk("rst flags", 64'({out_busy, out_stall, out_hi_wena, out_lo_wena}), 64'd0);
        chk("rst wdata", {out_hi_data, out_lo_data}, 64'd0);
        chk("rst hilo", {out_hi, out_lo}, 64'd0);
        in_rst = 1'b0;
        @(negedge in_clk);

        op(3'd1, 32'hFFFFFFFD, 32'd7, "mult_neg3x7");
        op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        op(3'd3, 32'hFFFFFFF9, 32'd2, "div_neg7by2");
        op(3'd4, 32'd100, 32'd0, "divu_by0");
        op(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        op(3'd3, 32'd12345, 32'd0, "div_by0");
        mv(1'b1, 32'hA5A5_0001, "mthi");
        mv(1'b0, 32'h5A5A_0002, "mtlo");

        // Ignored commands leave the unit idle.
        in_start = 1'b1;
        in_cmd   = 3'd7;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        in_cmd = 3'd0;
        @(negedge in_clk);
        chk("cmd7 ignored", 64'(out_busy), 64'd0);

        // MTHI held against a running DIV with rd_req from cycle T+5.
        ra = $urandom;
        rb = $urandom_range(1, 1000);
        hv = $urandom;
        e  = model(3'd3, ra, rb);
        in_start = 1'b1;
        in_cmd   = 3'd3;
        in_a     = ra;
        in_b     = rb;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge in_clk);
            if (k == 5) begin
                in_start  = 1'b1;
                in_cmd    = 3'd5;
                in_a      = hv;
                in_rd_req = 1'b1;
            end
            #1;
            chk("stall window", 64'({out_busy, out_stall}), 64'({1'b1, k >= 5}));
        end
        @(negedge in_clk);
        #1;
        chk("stall T+34", 64'({out_busy, out_stall}), 64'd0);
        chk("stall div hilo", {out_hi, out_lo}, e);
        @(posedge in_clk);
        #1 in_start = 1'b0;
        in_rd_req = 1'b0;
        in_cmd    = 3'd0;
        @(negedge in_clk);
        chk("mthi T+35 flags", 64'({out_busy, out_hi_wena, out_lo_wena}), 64'b110);
        chk("mthi T+35 data", 64'(out_hi_data), 64'(hv));
        @(negedge in_clk);
        chk("mthi after", {out_hi, out_lo}, {hv, e[31:0]});
        mhi = hv;
        mlo = e[31:0];

        // Flush in CALC at T+20.
        in_start = 1'b1;
        in_cmd   = 3'd1;
        in_a     = $urandom;
        in_b     = $urandom;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge in_clk);
            if (k == 20) in_flush = 1'b1;
        end
        @(posedge in_clk);
        #1 in_flush = 1'b0;
        @(negedge in_clk);
        chk("flush busy T+21", 64'(out_busy), 64'd0);
        for (int k = 0; k < 15; k++) begin
            @(negedge in_clk);
            chk("flush quiet", 64'({out_busy, out_hi_wena, out_lo_wena}), 64'd0);
        end
        chk("flush hilo", {out_hi, out_lo}, {mhi, mlo});

        // Flush in DONE beats the write.
        in_start = 1'b1;
        in_cmd   = 3'd4;
        in_a     = $urandom;
        in_b     = $urandom_range(1, 50);
        @(posedge in_clk);
        #1 in_start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge in_clk);
            if (k == 33) begin
                in_flush = 1'b1;
                #1;
                chk("flush done wena", 64'({out_busy, out_hi_wena, out_lo_wena}), 64'b100);
            end
        end
        @(posedge in_clk);
        #1 in_flush = 1'b0;
        @(negedge in_clk);
        chk("flush done hilo", {out_busy, out_hi, out_lo}, {1'b0, mhi, mlo});

        // Flush with a start in IDLE: nothing issues.
        in_start = 1'b1;
        in_flush = 1'b1;
        in_cmd   = 3'd1;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        in_flush = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(negedge in_clk);
            chk("idle flush quiet", 64'({out_busy, out_hi_wena, out_lo_wena}), 64'd0);
        end
        chk("idle flush hilo", {out_hi, out_lo}, {mhi, mlo});

        // Randomized operations.
        for (int i = 0; i < 14; i++) begin
            rc = 3'($urandom_range(1, 4));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 17);
                2:       rb = -$urandom_range(1, 17);
                default: rb = $urandom;
            endcase
            op(rc, ra, rb, "rand");
            if ($urandom_range(0, 2) == 0) mv($urandom_range(0, 1) == 1, $urandom, "rand mv");
        end

        // Reset in the middle of CALC.
        in_start = 1'b1;
        in_cmd   = 3'd2;
        in_a     = $urandom;
        in_b     = $urandom;
        @(posedge in_clk);
        #1 in_start = 1'b0;
        repeat (10) @(negedge in_clk);
        in_rst = 1'b1;
        #1;
        chk("midrst flags", 64'({out_busy, out_stall, out_hi_wena, out_lo_wena}), 64'd0);
        chk("midrst wdata", {out_hi_data, out_lo_data}, 64'd0);
        chk("midrst hilo", {out_hi, out_lo}, 64'd0);
        @(negedge in_clk);
        in_rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge in_clk);
            chk("post rst quiet", 64'({out_busy, out_hi_wena, out_lo_wena}), 64'd0);
        end
        chk("post rst hilo", {out_hi, out_lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Iterative multiply/divide unit that owns the architectural HI/LO registers.
- It is the write side of the HI/LO forwarding path. It produces the hi/lo data and write-enable pulses that the forwarding logic and the EXE/MEM pipeline registers consume.
- It stalls the decode stage while an operation is in flight.
- It sits in the EXE stage beside the ALU.

Parameters:
- DATA_W, 32, operand and HI/LO width. Iteration count equals DATA_W.
- DIVZ_LO, 32'hFFFFFFFF, value written to LO on divide by zero.

Ports:
- in_clk  input  1  clock, rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_start  input  1  request to issue in_cmd this cycle
- in_cmd  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- in_a  input  DATA_W  rs operand (dividend / multiplicand / MTHI / MTLO source)
- in_b  input  DATA_W  rt operand (divisor / multiplier)
- in_flush  input  1  abort the in-flight operation
- in_rd_req  input  1  decode stage holds MFHI/MFLO
- out_busy  output  1  operation in flight
- out_stall  output  1  combinational stall request to the pipeline
- out_hi_wena  output  1  one-cycle HI write pulse
- out_lo_wena  output  1  one-cycle LO write pulse
- out_hi_data  output  DATA_W  value being written to HI, valid while out_hi_wena=1
- out_lo_data  output  DATA_W  value being written to LO, valid while out_lo_wena=1
- out_hi  output  DATA_W  architectural HI
- out_lo  output  DATA_W  architectural LO

Behaviour:
- Reset (async, any state): state IDLE; HI, LO, counter and all internal regs are 0. Outputs out_busy, out_hi_wena, out_lo_wena are 0; out_hi_data, out_lo_data, out_hi, out_lo are 0.
- States: IDLE, CALC, DONE, MOVE.
- IDLE:
  - in_start with cmd 1-4: latch operands, take magnitudes for signed ops, record quotient/product sign and remainder sign, counter=0, go to CALC.
  - in_start with cmd 5/6: latch in_a, go to MOVE.
  - cmd 0/7 is ignored.
- CALC: one radix-2 step per cycle (shift-add multiply or restoring divide). Counter increments; after DATA_W steps go to DONE.
- DONE (1 cycle):
  - Apply sign correction.
  - Assert out_hi_wena and out_lo_wena, with out_hi_data/out_lo_data driven combinationally from the corrected result.
  - HI/LO update at the end of the cycle; return to IDLE.
- MOVE (1 cycle): assert only the matching wena with the data equal to the latched in_a; update that register; IDLE.
- Latency: start sampled at edge T.
  - Mul/div: out_busy is high in cycles T+1..T+DATA_W+1; CALC occupies T+1..T+32 and DONE is T+33 for DATA_W=32.
  - MTHI/MTLO: busy and wena high in cycle T+1 only.
- out_stall = (in_start & cmd≠0/7 & state≠IDLE) | (in_rd_req & state≠IDLE). A stalled in_start is not accepted; the requester holds it.
- Arithmetic:
  - Multiply: product is 2·DATA_W bits; HI takes the upper half, LO the lower half.
  - Signed result negated when the operand signs differ.
  - Divide: LO = quotient, HI = remainder; quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero (in_b=0, signed or unsigned): LO=DIVZ_LO, HI=in_a. Still takes full latency.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- in_flush: in CALC/DONE/MOVE it forces IDLE next cycle; no wena pulse occurs that cycle; HI/LO are unchanged. It has priority over the DONE write. In IDLE it overrides same-cycle in_start, which is then not accepted.
- Reset mid-operation: abort and clear HI/LO; no wena pulse is emitted.
- Wena pulses never last more than one cycle. Both pulses are never high in MOVE.

Test Plan:
- Reset: assert in_rst mid-CALC -> all outputs 0 immediately, state IDLE, no later wena.
- MULT a=0xFFFFFFFD (-3), b=7 at edge T:
  - busy T+1..T+33; both wena high only in T+33, with hi_data=0xFFFFFFFF, lo_data=0xFFFFFFEB.
  - out_hi/out_lo show those values from T+34.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100 after the full 33-cycle latency. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Issue DIV, then in_start MTHI and in_rd_req at T+5:
  - out_stall=1 through T+33 and MTHI is not accepted; it is accepted at T+34 and HI is written in T+35.
  - In T+35 only out_hi_wena=1 and LO is unchanged.
- Issue MULT, in_flush at T+20 -> busy low from T+21, no wena pulse, HI/LO retain their prior values. A flush together with an IDLE start does not issue.
